// File: rtl/bram_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl_pkg
// Shared defaults for the BRAM-backed FIFO controller: default word width and
// depth, plus the rule for sizing the wrapping read/write pointers (one bit
// wider than the RAM address so full and empty can be told apart).
// No ports.
// ---------------------------------------------------------------------------
package bram_fifo_ctrl_pkg;

    localparam int DEF_NB_WORD_RAM = 66;
    localparam int DEF_RAM_DEPTH   = 16;

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int ptr_width(input int nb_addr);
        return nb_addr + 1;
    endfunction

endpackage : bram_fifo_ctrl_pkg

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
// Wrapping binary counter used as a FIFO read or write pointer. Wraps
// naturally modulo 2^NB_PTR.
// Ports:
//   i_clock  clock
//   i_clear  synchronous clear to zero (priority over increment)
//   i_inc    increment enable
//   o_ptr    current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr #(
    parameter int NB_PTR = 5
) (
    input  logic              i_clock,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [NB_PTR-1:0] o_ptr
);

    logic [NB_PTR-1:0] ptr_q;
    logic [NB_PTR-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_clear) begin
            ptr_d = '0;
        end else if (i_inc) begin
            ptr_d = ptr_q + NB_PTR'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
// Pointer/flag controller that runs an external simple dual-port RAM
// (registered, read-before-write output) as a synchronous FIFO.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_flush                 synchronous clear of pointers, level and flags
//   i_push, i_data          write request and word
//   i_pop                   read request
//   o_ram_write_enable/addr, o_ram_data   RAM write port (combinational)
//   o_ram_read_enable/addr                RAM read port (combinational)
//   i_ram_data              RAM registered read data
//   o_data, o_data_valid    read word (pass-through of i_ram_data) and valid
//   o_empty, o_full, o_almost_full, o_level   status
//   o_overflow, o_underflow sticky error flags
// ---------------------------------------------------------------------------
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int NB_WORD_RAM  = DEF_NB_WORD_RAM,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int NB_ADDR_RAM  = $clog2(RAM_DEPTH),
    parameter int AF_THRESHOLD = RAM_DEPTH - 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [NB_WORD_RAM-1:0] i_data,
    input  logic                   i_pop,
    output logic                   o_ram_write_enable,
    output logic [NB_ADDR_RAM-1:0] o_ram_write_addr,
    output logic [NB_WORD_RAM-1:0] o_ram_data,
    output logic                   o_ram_read_enable,
    output logic [NB_ADDR_RAM-1:0] o_ram_read_addr,
    input  logic [NB_WORD_RAM-1:0] i_ram_data,
    output logic [NB_WORD_RAM-1:0] o_data,
    output logic                   o_data_valid,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic [NB_ADDR_RAM:0]   o_level,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int NB_PTR = ptr_width(NB_ADDR_RAM);
    localparam int NB_LVL = NB_ADDR_RAM + 1;
    localparam logic [NB_LVL-1:0] AF_LEVEL = NB_LVL'(AF_THRESHOLD);

    logic [NB_PTR-1:0] wr_ptr;
    logic [NB_PTR-1:0] rd_ptr;
    logic              clear;
    logic              empty;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    logic [NB_LVL-1:0] level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              valid_q, valid_d;

    // Reset and flush act identically on all controller state.
    assign clear = i_reset | i_flush;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[NB_PTR-1] != rd_ptr[NB_PTR-1]) &&
                   (wr_ptr[NB_ADDR_RAM-1:0] == rd_ptr[NB_ADDR_RAM-1:0]);

    // Accept decisions depend only on registered pointers; a push into a
    // full FIFO is allowed when a pop frees the head slot in the same cycle.
    assign pop_ok  = i_pop & ~empty & ~clear;
    assign push_ok = i_push & (~full | pop_ok) & ~clear;

    fifo_ptr #(.NB_PTR(NB_PTR)) u_wr_ptr (
        .i_clock (i_clock),
        .i_clear (clear),
        .i_inc   (push_ok),
        .o_ptr   (wr_ptr)
    );

    fifo_ptr #(.NB_PTR(NB_PTR)) u_rd_ptr (
        .i_clock (i_clock),
        .i_clear (clear),
        .i_inc   (pop_ok),
        .o_ptr   (rd_ptr)
    );

    always_comb begin
        level_d     = level_q;
        overflow_d  = overflow_q | (i_push & full & ~pop_ok);
        underflow_d = underflow_q | (i_pop & empty);
        valid_d     = pop_ok;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + NB_LVL'(1);
            2'b01:   level_d = level_q - NB_LVL'(1);
            default: level_d = level_q;
        endcase
        if (clear) begin
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        level_q     <= level_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
        valid_q     <= valid_d;
    end

    assign o_ram_write_enable = push_ok;
    assign o_ram_write_addr   = wr_ptr[NB_ADDR_RAM-1:0];
    assign o_ram_data         = i_data;
    assign o_ram_read_enable  = pop_ok;
    assign o_ram_read_addr    = rd_ptr[NB_ADDR_RAM-1:0];

    assign o_data        = i_ram_data;
    assign o_data_valid  = valid_q;
    assign o_empty       = empty;
    assign o_full        = full;
    assign o_level       = level_q;
    assign o_almost_full = (level_q >= AF_LEVEL);
    assign o_overflow    = overflow_q;
    assign o_underflow   = underflow_q;

endmodule : bram_fifo_ctrl
